apple_manage_module: RTL and testbench
======================================

APPLE_MANAGE_MODULE -- requirements
Module: apple_manage_module

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning:
- GRID_X, 40, playfield columns.
- GRID_Y, 30, playfield rows.
- GREEN_STEPS, 64, snake steps a green apple survives.
- MAX_TRY, 8, rejected placements before fallback.
- LFSR_SEED, 16'hACE1, LFSR reset value.
REQ-002 SHALL have one clock; reset is synchronous and active-high. Ports, one per line: name, direction, width, meaning:
- Clk_50mhz, in, 1, 50 MHz system clock.
- Rst, in, 1, synchronous active-high reset.
- Game_status, in, 3, one-hot: START=001, PLAY=010, END=100.
- Head_x, in, 6, snake head column.
- Head_y, in, 5, snake head row.
- Head_valid, in, 1, one-cycle pulse per snake step; Head_x/Head_y are valid with it.
- Apple_x, out, 6, apple column.
- Apple_y, out, 5, apple row.
- Apple_valid, out, 1, an apple is on the field.
- Apple_type, out, 1, 0 = red, 1 = green.
- Body_add_sig, out, 1, one-cycle pulse when the apple is eaten; feeds the score/display stage.

Function
REQ-003 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle regardless of state.
REQ-004 SHALL implement FSM states IDLE, PLACE and ACTIVE.
REQ-005 SHALL enter IDLE from any state in the cycle after Game_status != 010.
- In IDLE: Apple_valid=0 and Body_add_sig=0.
- Apple_x, Apple_y and Apple_type hold their last values.
REQ-006 SHALL go IDLE -> PLACE in the cycle after Game_status == 010.
REQ-007 In PLACE, SHALL form a candidate each cycle:
- x = lfsr[5:0], y = lfsr[10:6], type = (lfsr[13:12] == 2'b00).
REQ-008 SHALL accept a candidate only if x < GRID_X, y < GRID_Y, and (x,y) != (Head_x,Head_y).
- Otherwise retry next cycle and increment the try counter.
REQ-009 After MAX_TRY consecutive rejections, SHALL place a fallback apple:
- Position (0,0), or (1,0) if the head is at (0,0); type red.
REQ-010 On accept or fallback, SHALL do all of the following:
- Register Apple_x, Apple_y and Apple_type.
- Assert Apple_valid from the next cycle.
- Clear the try counter and the step counter.
- Go to ACTIVE.
REQ-011 In ACTIVE, on Head_valid with (Head_x,Head_y) == (Apple_x,Apple_y), SHALL do all of the following:
- Pulse Body_add_sig for exactly one cycle, the next cycle.
- Drop Apple_valid in that same cycle.
- Go to PLACE.
REQ-012 Apple_type SHALL remain the eaten apple's type during the Body_add_sig pulse, and SHALL change only on the next placement.
REQ-013 For a green apple in ACTIVE, SHALL count Head_valid pulses with a 7-bit step counter.
- When the count reaches GREEN_STEPS without being eaten: Apple_valid=0, go to PLACE, no Body_add_sig.
REQ-014 If the eat condition and green expiry occur in the same cycle, eating SHALL win: Body_add_sig pulses.
REQ-015 Red apples SHALL never expire.
REQ-016 A Game_status change away from PLAY in the same cycle as an eat SHALL suppress the pulse; leaving PLAY has priority.
REQ-017 Body_add_sig SHALL never be high in two consecutive cycles.
REQ-018 Minimum eat-to-new-apple latency SHALL be 2 cycles: pulse cycle, then PLACE accept, then Apple_valid.

Reset
REQ-019 While Rst=1 at a clock edge, the block SHALL set:
- state = IDLE, lfsr = LFSR_SEED, try counter = 0, step counter = 0.
- Apple_x = 0, Apple_y = 0, Apple_type = 0, Apple_valid = 0, Body_add_sig = 0.
REQ-020 Reset asserted mid-PLACE or mid-ACTIVE SHALL abort without producing a Body_add_sig pulse.

Structure
REQ-021 A shared game package SHALL hold:
- Game_status encodings START/PLAY/END.
- GRID_X/GRID_Y defaults.
- Apple type encodings RED=0, GREEN=1.
REQ-022 The LFSR SHALL be a separate sub-module lfsr16_module with ports Clk_50mhz, Rst, Seed[15:0] and Lfsr_out[15:0].
- All other logic is flat in apple_manage_module.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset: Rst=1 for 3 cycles, then release with Game_status=001 -> all outputs 0; state IDLE for 100 cycles.
- Placement: Game_status=010 -> Apple_valid=1 within MAX_TRY+2 cycles; Apple_x<40, Apple_y<30; apple position != head.
- Eat red: drive head to (Apple_x,Apple_y) with Head_valid -> Body_add_sig=1 for exactly 1 cycle; Apple_type=0 during the pulse; new Apple_valid 2 cycles later.
- Green expiry: force a green apple, issue 64 non-matching Head_valid pulses -> Apple_valid drops; no Body_add_sig; re-placement follows.
- Simultaneous: on the 64th step the head matches the green apple -> Body_add_sig=1 with Apple_type=1.
- Status abort: eat in the same cycle Game_status becomes 100 -> no pulse; Apple_valid=0 next cycle; a return to 010 re-places an apple.

Source files
------------

// File: rtl/apple_manage_module_pkg.sv
// Shared game encodings and apple-manager types.
package apple_manage_module_pkg;

    // Game_status one-hot encodings
    localparam logic [2:0] GS_START = 3'b001;
    localparam logic [2:0] GS_PLAY  = 3'b010;
    localparam logic [2:0] GS_END   = 3'b100;

    // Playfield defaults
    localparam int DEF_GRID_X = 40;
    localparam int DEF_GRID_Y = 30;

    // Apple type encodings
    localparam logic APPLE_RED   = 1'b0;
    localparam logic APPLE_GREEN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLACE  = 2'd1,
        ST_ACTIVE = 2'd2
    } apple_state_e;

    typedef struct packed {
        logic [5:0] x;
        logic [4:0] y;
        logic       kind;
    } apple_t;

endpackage

// File: rtl/apple_manage_module_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
// A zero seed locks the register at zero; callers must pass a non-zero seed.
module lfsr16_module (
    input  logic        Clk_50mhz,
    input  logic        Rst,
    input  logic [15:0] Seed,
    output logic [15:0] Lfsr_out
);

    logic fb;

    assign fb = Lfsr_out[15] ^ Lfsr_out[13] ^ Lfsr_out[12] ^ Lfsr_out[10];

    // Shift left every cycle, feedback enters at bit 0
    always_ff @(posedge Clk_50mhz) begin
        if (Rst) Lfsr_out <= Seed;
        else     Lfsr_out <= {Lfsr_out[14:0], fb};
    end

endmodule

// File: rtl/apple_manage_module.sv
// Apple placement / eat / green-expiry manager for the snake game.
module apple_manage_module
    import apple_manage_module_pkg::*;
#(
    parameter int          GRID_X      = DEF_GRID_X,
    parameter int          GRID_Y      = DEF_GRID_Y,
    parameter int          GREEN_STEPS = 64,
    parameter int          MAX_TRY     = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       Clk_50mhz,
    input  logic       Rst,
    input  logic [2:0] Game_status,
    input  logic [5:0] Head_x,
    input  logic [4:0] Head_y,
    input  logic       Head_valid,
    output logic [5:0] Apple_x,
    output logic [4:0] Apple_y,
    output logic       Apple_valid,
    output logic       Apple_type,
    output logic       Body_add_sig
);

    localparam int TRY_W = $clog2(MAX_TRY + 1);

    apple_state_e     state, state_n;
    logic [15:0]      lfsr;
    logic [TRY_W-1:0] try_cnt, try_cnt_n;
    logic [6:0]       step_cnt, step_cnt_n;
    apple_t           apple, apple_n;
    logic             valid_n, body_n;

    logic [5:0] cand_x;
    logic [4:0] cand_y;
    logic       cand_type;
    logic       cand_ok;
    logic       head_hit;
    logic       steps_done;
    logic       head_at_origin;

    lfsr16_module u_lfsr (
        .Clk_50mhz (Clk_50mhz),
        .Rst       (Rst),
        .Seed      (LFSR_SEED),
        .Lfsr_out  (lfsr)
    );

    assign cand_x         = lfsr[5:0];
    assign cand_y         = lfsr[10:6];
    assign cand_type      = (lfsr[13:12] == 2'b00);
    assign head_at_origin = (Head_x == 6'd0) && (Head_y == 5'd0);
    assign cand_ok        = ({1'b0, cand_x} < 7'(GRID_X)) &&
                            ({1'b0, cand_y} < 6'(GRID_Y)) &&
                            !((cand_x == Head_x) && (cand_y == Head_y));
    assign head_hit       = Head_valid && (Head_x == apple.x) && (Head_y == apple.y);
    // The pulse being counted now is the one that reaches the limit
    assign steps_done     = ((step_cnt + 7'd1) == 7'(GREEN_STEPS));

    assign Apple_x    = apple.x;
    assign Apple_y    = apple.y;
    assign Apple_type = apple.kind;

    // Next-state and next-output logic; leaving PLAY overrides everything
    always_comb begin
        state_n    = state;
        try_cnt_n  = try_cnt;
        step_cnt_n = step_cnt;
        apple_n    = apple;
        valid_n    = Apple_valid;
        body_n     = 1'b0;
        if (Game_status != GS_PLAY) begin
            state_n    = ST_IDLE;
            valid_n    = 1'b0;
            try_cnt_n  = '0;
            step_cnt_n = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n   = ST_PLACE;
                    try_cnt_n = '0;
                end
                ST_PLACE: begin
                    if (cand_ok) begin
                        apple_n    = '{x: cand_x, y: cand_y, kind: cand_type};
                        valid_n    = 1'b1;
                        try_cnt_n  = '0;
                        step_cnt_n = '0;
                        state_n    = ST_ACTIVE;
                    end else if (try_cnt == TRY_W'(MAX_TRY - 1)) begin
                        // This rejection is the last allowed one: fall back
                        apple_n    = '{x: (head_at_origin ? 6'd1 : 6'd0), y: 5'd0, kind: APPLE_RED};
                        valid_n    = 1'b1;
                        try_cnt_n  = '0;
                        step_cnt_n = '0;
                        state_n    = ST_ACTIVE;
                    end else begin
                        try_cnt_n = try_cnt + 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (head_hit) begin
                        // Eating wins over a simultaneous green expiry
                        body_n  = 1'b1;
                        valid_n = 1'b0;
                        state_n = ST_PLACE;
                    end else if (Head_valid && (apple.kind == APPLE_GREEN)) begin
                        step_cnt_n = step_cnt + 7'd1;
                        if (steps_done) begin
                            valid_n = 1'b0;
                            state_n = ST_PLACE;
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    valid_n = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge Clk_50mhz) begin
        if (Rst) begin
            state        <= ST_IDLE;
            try_cnt      <= '0;
            step_cnt     <= '0;
            apple        <= '0;
            Apple_valid  <= 1'b0;
            Body_add_sig <= 1'b0;
        end else begin
            state        <= state_n;
            try_cnt      <= try_cnt_n;
            step_cnt     <= step_cnt_n;
            apple        <= apple_n;
            Apple_valid  <= valid_n;
            Body_add_sig <= body_n;
        end
    end

endmodule

// File: tb/tb_apple_manage_module.sv
// Self-checking bench for apple_manage_module: LFSR reference model predicts
// every placement, a queue scoreboards eat pulses, a table drives ACTIVE cases.
module tb_apple_manage_module;
    import apple_manage_module_pkg::*;

    localparam int          MAX_TRY     = 8;
    localparam int          GREEN_STEPS = 64;
    localparam logic [15:0] SEED        = 16'hACE1;

    logic       Clk_50mhz   = 1'b0;
    logic       Rst         = 1'b1;
    logic [2:0] Game_status = GS_START;
    logic [5:0] Head_x      = 6'd63;
    logic [4:0] Head_y      = 5'd31;
    logic       Head_valid  = 1'b0;
    logic [5:0] Apple_x;
    logic [4:0] Apple_y;
    logic       Apple_valid;
    logic       Apple_type;
    logic       Body_add_sig;

    int checks   = 0;
    int failures = 0;

    always #10 Clk_50mhz = ~Clk_50mhz;

    apple_manage_module #(
        .GRID_X      (40),
        .GRID_Y      (30),
        .GREEN_STEPS (GREEN_STEPS),
        .MAX_TRY     (MAX_TRY),
        .LFSR_SEED   (SEED)
    ) dut (
        .Clk_50mhz    (Clk_50mhz),
        .Rst          (Rst),
        .Game_status  (Game_status),
        .Head_x       (Head_x),
        .Head_y       (Head_y),
        .Head_valid   (Head_valid),
        .Apple_x      (Apple_x),
        .Apple_y      (Apple_y),
        .Apple_valid  (Apple_valid),
        .Apple_type   (Apple_type),
        .Body_add_sig (Body_add_sig)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference LFSR and the head position as seen at each edge
    logic [15:0] ref_lfsr, ref_prev;
    logic [5:0]  hx_q;
    logic [4:0]  hy_q;
    always @(posedge Clk_50mhz) begin
        ref_prev <= ref_lfsr;
        hx_q     <= Head_x;
        hy_q     <= Head_y;
        if (Rst) ref_lfsr <= SEED;
        else     ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
    end

    // Candidate the DUT should have evaluated at the last edge
    logic [5:0] c_x, fb_x;
    logic [4:0] c_y;
    logic       c_t, c_ok;
    assign c_x  = ref_prev[5:0];
    assign c_y  = ref_prev[10:6];
    assign c_t  = (ref_prev[13:12] == 2'b00);
    assign c_ok = (c_x < 6'd40) && (c_y < 5'd30) && !((c_x == hx_q) && (c_y == hy_q));
    assign fb_x = ((hx_q == 6'd0) && (hy_q == 5'd0)) ? 6'd1 : 6'd0;

    // Model's view of the current apple
    logic [5:0] cur_x    = '0;
    logic [4:0] cur_y    = '0;
    logic       cur_type = 1'b0;
    logic       valid_d  = 1'b0;
    logic       body_d   = 1'b0;
    logic       sb_q[$];

    // Monitor: placement prediction on Apple_valid rise, scoreboard on pulses
    always @(negedge Clk_50mhz) begin
        if (!Rst && Apple_valid && !valid_d) begin
            if (c_ok) begin
                chk("place_x", Apple_x, c_x);
                chk("place_y", Apple_y, c_y);
                chk("place_type", Apple_type, c_t);
                cur_x    <= c_x;
                cur_y    <= c_y;
                cur_type <= c_t;
            end else begin
                chk("fallback_x", Apple_x, fb_x);
                chk("fallback_y", Apple_y, 0);
                chk("fallback_type", Apple_type, 0);
                cur_x    <= fb_x;
                cur_y    <= 5'd0;
                cur_type <= 1'b0;
            end
            chk("place_in_grid", (Apple_x < 6'd40) && (Apple_y < 5'd30), 1);
            chk("place_not_head", (Apple_x == hx_q) && (Apple_y == hy_q), 0);
        end
        if (Body_add_sig) begin
            chk("pulse_single", body_d, 0);
            chk("pulse_valid_low", Apple_valid, 0);
            if (sb_q.size() == 0) chk("pulse_expected", Body_add_sig, 0);
            else                  chk("pulse_type", Apple_type, sb_q.pop_front());
        end
        valid_d <= Apple_valid;
        body_d  <= Body_add_sig;
    end

    task automatic head_off();
        Head_valid = 1'b0;
        Head_x     = 6'd63;
        Head_y     = 5'd31;
    endtask

    // Wait (bounded) for Apple_valid; n = negedges waited, -1 on timeout
    task automatic wait_valid(output int n);
        n = 0;
        while (!Apple_valid && n < 40) begin
            @(negedge Clk_50mhz);
            n++;
        end
        if (!Apple_valid) n = -1;
        #1;
    endtask

    task automatic eat_current();
        Head_x     = cur_x;
        Head_y     = cur_y;
        Head_valid = 1'b1;
        sb_q.push_back(cur_type);
        @(negedge Clk_50mhz);
        head_off();
    endtask

    // Eat apples until one of the wanted type is on the field
    task automatic get_apple(input logic want, output bit ok);
        int n;
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            wait_valid(n);
            if (n < 0) break;
            if (cur_type == want) ok = 1'b1;
            else                  eat_current();
        end
    endtask

    typedef struct {
        logic [2:0] st;
        logic       hv;
        logic [5:0] dx;
        logic [4:0] dy;
        logic       body;
        logic       valid;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n;
        bit ok;
        bit bad;

        tbl[0] = '{GS_PLAY,  1'b1, 6'd1, 5'd0, 1'b0, 1'b1};
        tbl[1] = '{GS_PLAY,  1'b0, 6'd0, 5'd0, 1'b0, 1'b1};
        tbl[2] = '{GS_PLAY,  1'b1, 6'd0, 5'd1, 1'b0, 1'b1};
        tbl[3] = '{GS_PLAY,  1'b1, 6'd0, 5'd0, 1'b1, 1'b0};
        tbl[4] = '{GS_END,   1'b1, 6'd0, 5'd0, 1'b0, 1'b0};
        tbl[5] = '{GS_START, 1'b1, 6'd0, 5'd0, 1'b0, 1'b0};
        tbl[6] = '{GS_PLAY,  1'b1, 6'd0, 5'd0, 1'b1, 1'b0};

        // Reset for 3 cycles, then idle in START
        Rst = 1'b1;
        Game_status = GS_START;
        repeat (3) @(negedge Clk_50mhz);
        Rst = 1'b0;
        chk("rst_apple_x", Apple_x, 0);
        chk("rst_apple_y", Apple_y, 0);
        chk("rst_apple_type", Apple_type, 0);
        chk("rst_apple_valid", Apple_valid, 0);
        chk("rst_body_add", Body_add_sig, 0);
        bad = 1'b0;
        repeat (100) begin
            @(negedge Clk_50mhz);
            if (Apple_valid || Body_add_sig) bad = 1'b1;
        end
        chk("idle_100_quiet", bad, 0);

        // First placement latency
        Game_status = GS_PLAY;
        wait_valid(n);
        chk("place_latency_ok", (n >= 2) && (n <= MAX_TRY + 2), 1);

        // Table of single-cycle ACTIVE stimuli
        for (int i = 0; i < 7; i++) begin
            Game_status = GS_PLAY;
            wait_valid(n);
            chk($sformatf("tbl%0d_placed", i), n >= 0, 1);
            Game_status = tbl[i].st;
            Head_x      = cur_x + tbl[i].dx;
            Head_y      = cur_y + tbl[i].dy;
            Head_valid  = tbl[i].hv;
            if (tbl[i].body) sb_q.push_back(cur_type);
            @(negedge Clk_50mhz);
            head_off();
            Game_status = GS_PLAY;
            chk($sformatf("tbl%0d_body", i), Body_add_sig, tbl[i].body);
            chk($sformatf("tbl%0d_valid", i), Apple_valid, tbl[i].valid);
        end

        // Eat a red apple: one-cycle pulse, type held, re-place after
        get_apple(APPLE_RED, ok);
        chk("red_found", ok, 1);
        eat_current();
        chk("red_pulse", Body_add_sig, 1);
        chk("red_type_in_pulse", Apple_type, 0);
        chk("red_valid_drop", Apple_valid, 0);
        @(negedge Clk_50mhz);
        chk("red_pulse_len", Body_add_sig, 0);
        wait_valid(n);
        chk("red_replace_ok", (n >= 0) && (n <= MAX_TRY), 1);

        // Green expiry after GREEN_STEPS non-matching steps
        get_apple(APPLE_GREEN, ok);
        chk("green_found", ok, 1);
        Head_valid = 1'b1;
        for (int k = 1; k <= GREEN_STEPS; k++) begin
            @(negedge Clk_50mhz);
            if (k == GREEN_STEPS - 1) chk("green_alive", Apple_valid, 1);
        end
        head_off();
        chk("green_expired", Apple_valid, 0);
        chk("green_no_pulse", Body_add_sig, 0);
        wait_valid(n);
        chk("green_replace_ok", (n >= 0) && (n <= MAX_TRY + 1), 1);

        // Eat on the expiring step: eating wins
        get_apple(APPLE_GREEN, ok);
        chk("green2_found", ok, 1);
        Head_valid = 1'b1;
        repeat (GREEN_STEPS - 1) @(negedge Clk_50mhz);
        chk("sim_alive", Apple_valid, 1);
        eat_current();
        chk("sim_pulse", Body_add_sig, 1);
        chk("sim_type", Apple_type, 1);
        chk("sim_valid_drop", Apple_valid, 0);

        // Reset while an eat is presented: no pulse
        wait_valid(n);
        chk("pre_rst_placed", n >= 0, 1);
        Head_x     = cur_x;
        Head_y     = cur_y;
        Head_valid = 1'b1;
        Rst        = 1'b1;
        @(negedge Clk_50mhz);
        Rst = 1'b0;
        head_off();
        chk("rst_mid_no_pulse", Body_add_sig, 0);
        chk("rst_mid_valid", Apple_valid, 0);
        chk("rst_mid_x", Apple_x, 0);
        wait_valid(n);
        chk("post_rst_placed", n >= 0, 1);
        repeat (2) @(negedge Clk_50mhz);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
